hwpe_stream_job_sequencer: RTL and testbench

Sequences a job across up to NB_STREAMS HWPE source/sink streamers. It accepts a job descriptor and waits until every enabled streamer reports ready_start. It then fires req_start on all enabled streamers in the same cycle and collects their done pulses. It repeats this for nb_iter iterations, advancing each stream's base address by a per-stream stride. It sits between the engine controller/register file and the streamers' ctrl/flags ports.

---
 rtl/hwpe_stream_job_sequencer_pkg.sv | 69 ++++++
 rtl/hwpe_stream_done_collector.sv | 37 +++
 rtl/hwpe_stream_job_sequencer.sv | 141 ++++++++++++++
 tb/tb_hwpe_stream_job_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hwpe_stream_job_sequencer_pkg.sv
// Package for the HWPE stream job sequencer.
// Holds the streamer control/flag types shared with the source/sink
// streamers, the sequencer FSM state type, and the job control/flag structs.
// It also provides a helper that folds the sequencer state onto the coarse
// streamer state encoding.
package hwpe_stream_job_sequencer_pkg;

  localparam int unsigned JOB_SEQ_MAX_STREAMS = 16;
  localparam int unsigned JOB_SEQ_ITER_WIDTH  = 16;

  typedef struct packed {
    logic [31:0] base_addr;
    logic [31:0] trans_size;
    logic [15:0] line_stride;
    logic [15:0] line_length;
    logic [15:0] feat_stride;
    logic [15:0] feat_length;
    logic [15:0] feat_roll;
    logic        loop_outer;
    logic        realign_type;
    logic [7:0]  step;
  } ctrl_addressgen_t;

  typedef struct packed {
    logic             req_start;
    ctrl_addressgen_t addressgen_ctrl;
  } ctrl_sourcesink_t;

  typedef struct packed {
    logic ready_start;
    logic done;
  } flags_sourcesink_t;

  typedef enum logic [1:0] {
    STREAM_IDLE,
    STREAM_WORKING,
    STREAM_DONE
  } state_sourcesink_t;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_START,
    SEQ_WAIT,
    SEQ_NEXT,
    SEQ_DONE
  } seq_state_t;

  typedef struct packed {
    logic [JOB_SEQ_MAX_STREAMS-1:0] stream_en;
    logic [JOB_SEQ_ITER_WIDTH-1:0]  nb_iter;
  } ctrl_job_seq_t;

  typedef struct packed {
    logic                          busy;
    logic                          done;
    logic [JOB_SEQ_ITER_WIDTH-1:0] iter;
  } flags_job_seq_t;

  function automatic state_sourcesink_t seq_to_stream_state(input seq_state_t s);
    state_sourcesink_t r;
    unique case (s)
      SEQ_IDLE: r = STREAM_IDLE;
      SEQ_DONE: r = STREAM_DONE;
      default:  r = STREAM_WORKING;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hwpe_stream_done_collector.sv
// Sticky per-stream done tracker with an all-done reduction.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   clear      synchronous abort, drops all sticky bits
//   capture    high while the sequencer waits for done pulses; the
//              sticky bits are held at zero whenever it is low
//   mask       per-stream enable mask of the current job
//   done       per-stream done pulses from the streamers
//   all_done   every enabled stream has finished, counting a done
//              pulse arriving in the current cycle
module hwpe_stream_done_collector #(
  parameter int unsigned NB_STREAMS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  capture,
  input  logic [NB_STREAMS-1:0] mask,
  input  logic [NB_STREAMS-1:0] done,
  output logic                  all_done
);

  logic [NB_STREAMS-1:0] done_seen;

  // Outside the wait window the sticky bits are held clear, which covers
  // both the per-iteration clear and stray pulses between jobs.
  always_ff @(posedge clk) begin
    if (rst || clear || !capture) begin
      done_seen <= '0;
    end else begin
      done_seen <= done_seen | (done & mask);
    end
  end

  assign all_done = &(~mask | done_seen | done);

endmodule

// File: rtl/hwpe_stream_job_sequencer.sv
// Job sequencer for a group of HWPE source/sink streamers.
// It accepts a job descriptor, waits for every enabled streamer to report
// ready_start, and then fires req_start on all of them in one cycle. It
// collects their done pulses and repeats this for nb_iter iterations. After
// each iteration every stream's base address advances by its stride.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   clear_i           synchronous soft abort back to idle
//   job_valid_i       job descriptor valid; accepted while job_ready_o
//   job_ready_o       high in idle only
//   stream_en_i       per-stream enable mask
//   nb_iter_i         iteration count (0 runs one iteration)
//   cfg_i             per-stream address generator configuration
//   iter_stride_i     per-stream base address increment per iteration
//   ctrl_o            control to the streamers
//   flags_i           flags from the streamers
//   busy_o            job in progress
//   done_o            one-cycle job-complete pulse
//   iter_o            current iteration index
//   state_o           coarse state (idle / working / done)
module hwpe_stream_job_sequencer
  import hwpe_stream_job_sequencer_pkg::*;
#(
  parameter int unsigned NB_STREAMS = 3,
  parameter int unsigned ITER_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  job_valid_i,
  output logic                  job_ready_o,
  input  logic [NB_STREAMS-1:0] stream_en_i,
  input  logic [ITER_WIDTH-1:0] nb_iter_i,
  input  ctrl_addressgen_t      cfg_i         [NB_STREAMS],
  input  logic [31:0]           iter_stride_i [NB_STREAMS],
  output ctrl_sourcesink_t      ctrl_o        [NB_STREAMS],
  input  flags_sourcesink_t     flags_i       [NB_STREAMS],
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ITER_WIDTH-1:0] iter_o,
  output state_sourcesink_t     state_o
);

  seq_state_t            state;
  logic [NB_STREAMS-1:0] mask;
  logic [ITER_WIDTH-1:0] nb_iter;
  logic [ITER_WIDTH-1:0] iter;
  ctrl_addressgen_t      cfg    [NB_STREAMS];
  logic [31:0]           stride [NB_STREAMS];

  logic [NB_STREAMS-1:0] ready_vec;
  logic [NB_STREAMS-1:0] done_vec;
  logic                  go;
  logic                  all_done;

  always_comb begin
    ready_vec = '0;
    done_vec  = '0;
    for (int unsigned k = 0; k < NB_STREAMS; k++) begin
      ready_vec[k] = flags_i[k].ready_start;
      done_vec[k]  = flags_i[k].done;
    end
  end

  assign go = &(~mask | ready_vec);

  hwpe_stream_done_collector #(
    .NB_STREAMS (NB_STREAMS)
  ) i_done_collector (
    .clk      (clk_i),
    .rst      (rst_i),
    .clear    (clear_i),
    .capture  (state == SEQ_WAIT),
    .mask     (mask),
    .done     (done_vec),
    .all_done (all_done)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state   <= SEQ_IDLE;
      mask    <= '0;
      nb_iter <= '0;
      iter    <= '0;
      cfg     <= '{default: '0};
      stride  <= '{default: '0};
    end else begin
      unique case (state)
        SEQ_IDLE: begin
          if (job_valid_i) begin
            mask    <= stream_en_i;
            cfg     <= cfg_i;
            stride  <= iter_stride_i;
            nb_iter <= (nb_iter_i == '0) ? ITER_WIDTH'(1) : nb_iter_i;
            iter    <= '0;
            state   <= (stream_en_i != '0) ? SEQ_START : SEQ_DONE;
          end
        end
        SEQ_START: begin
          if (go) begin
            state <= SEQ_WAIT;
          end
        end
        SEQ_WAIT: begin
          if (all_done) begin
            state <= (iter == nb_iter - ITER_WIDTH'(1)) ? SEQ_DONE : SEQ_NEXT;
          end
        end
        SEQ_NEXT: begin
          iter <= iter + ITER_WIDTH'(1);
          for (int unsigned k = 0; k < NB_STREAMS; k++) begin
            cfg[k].base_addr <= cfg[k].base_addr + stride[k];
          end
          state <= SEQ_START;
        end
        SEQ_DONE: begin
          state <= SEQ_IDLE;
        end
        default: begin
          state <= SEQ_IDLE;
        end
      endcase
    end
  end

  // req_start is combinational so the streamers launch in the same cycle the
  // last ready_start arrives; leaving START right after keeps it single-cycle.
  always_comb begin
    for (int unsigned k = 0; k < NB_STREAMS; k++) begin
      ctrl_o[k].req_start       = (state == SEQ_START) && go && mask[k];
      ctrl_o[k].addressgen_ctrl = cfg[k];
    end
  end

  assign job_ready_o = (state == SEQ_IDLE);
  assign busy_o      = (state != SEQ_IDLE);
  assign done_o      = (state == SEQ_DONE);
  assign iter_o      = iter;
  assign state_o     = seq_to_stream_state(state);

endmodule

// File: tb/tb_hwpe_stream_job_sequencer.sv
// Directed testbench for hwpe_stream_job_sequencer.
// Inputs change 1 time unit after the rising edge. Outputs are sampled 1
// time unit later, so combinational req_start reflects the current inputs.
module tb_hwpe_stream_job_sequencer;
  import hwpe_stream_job_sequencer_pkg::*;

  localparam int unsigned NB = 3;
  localparam int unsigned IW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic              job_valid;
  logic              job_ready;
  logic [NB-1:0]     stream_en;
  logic [IW-1:0]     nb_iter;
  ctrl_addressgen_t  cfg    [NB];
  logic [31:0]       stride [NB];
  ctrl_sourcesink_t  ctrl   [NB];
  flags_sourcesink_t flags  [NB];
  logic              busy;
  logic              done;
  logic [IW-1:0]     iter;
  state_sourcesink_t state;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0]   exp_base [4];
  logic [NB-1:0] req_seen;
  int unsigned   req_count;

  always #5 clk = ~clk;

  hwpe_stream_job_sequencer #(
    .NB_STREAMS (NB),
    .ITER_WIDTH (IW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .clear_i       (clear),
    .job_valid_i   (job_valid),
    .job_ready_o   (job_ready),
    .stream_en_i   (stream_en),
    .nb_iter_i     (nb_iter),
    .cfg_i         (cfg),
    .iter_stride_i (stride),
    .ctrl_o        (ctrl),
    .flags_i       (flags),
    .busy_o        (busy),
    .done_o        (done),
    .iter_o        (iter),
    .state_o       (state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NB-1:0] reqs();
    logic [NB-1:0] r;
    for (int k = 0; k < NB; k++) r[k] = ctrl[k].req_start;
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    job_valid = 1'b0;
    stream_en = '0;
    nb_iter   = '0;
    cfg       = '{default: '0};
    stride    = '{default: '0};
    flags     = '{default: '0};
    exp_base[0] = 32'hFFFF_FF00;
    exp_base[1] = 32'h0000_0000;
    exp_base[2] = 32'h0000_0100;
    exp_base[3] = 32'h0000_0200;
    repeat (3) cyc();
    rst = 1'b0;
    #1;

    // Reset state
    check_eq("rst_job_ready", 32'(job_ready), 1);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_iter", 32'(iter), 0);
    check_eq("rst_state", 32'(state), 32'(STREAM_IDLE));
    check_eq("rst_req", 32'(reqs()), 0);
    check_eq("rst_base0", ctrl[0].addressgen_ctrl.base_addr, 0);

    // Test 1: single stream, one iteration, always ready
    for (int k = 0; k < NB; k++) flags[k].ready_start = 1'b1;
    cyc();
    job_valid = 1'b1; stream_en = 3'b001; nb_iter = 16'd1;
    cfg[0].base_addr = 32'h0000_1000;
    #1;
    check_eq("t1_ready_before", 32'(job_ready), 1);
    cyc();                                         // accept at T
    job_valid = 1'b0;
    #1;
    check_eq("t1_req_t1", 32'(reqs()), 3'b001);
    check_eq("t1_base", ctrl[0].addressgen_ctrl.base_addr, 32'h0000_1000);
    check_eq("t1_busy", 32'(busy), 1);
    check_eq("t1_job_ready_low", 32'(job_ready), 0);
    cyc();
    for (int c = 2; c <= 9; c++) begin
      #1;
      check_eq("t1_wait_req", 32'(reqs()), 0);
      check_eq("t1_wait_done", 32'(done), 0);
      cyc();
    end
    flags[0].done = 1'b1;                          // done at T+10
    #1;
    check_eq("t1_done_not_yet", 32'(done), 0);
    cyc();
    flags[0].done = 1'b0;
    #1;
    check_eq("t1_done_pulse", 32'(done), 1);
    check_eq("t1_ready_still_low", 32'(job_ready), 0);
    check_eq("t1_state_done", 32'(state), 32'(STREAM_DONE));
    cyc();
    #1;
    check_eq("t1_job_ready", 32'(job_ready), 1);
    check_eq("t1_done_single", 32'(done), 0);
    check_eq("t1_idle_busy", 32'(busy), 0);

    // Tests 2/3: three streams, stream 2 ready late, staggered dones
    flags[2].ready_start = 1'b0;
    job_valid = 1'b1; stream_en = 3'b111; nb_iter = 16'd1;
    cfg[0].base_addr = 32'h2000; cfg[1].base_addr = 32'h3000; cfg[2].base_addr = 32'h4000;
    cyc();
    job_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      check_eq("t2_req_held", 32'(reqs()), 0);
      cyc();
    end
    flags[2].ready_start = 1'b1;
    #1;
    check_eq("t2_req_all", 32'(reqs()), 3'b111);
    check_eq("t2_base2", ctrl[2].addressgen_ctrl.base_addr, 32'h4000);
    cyc();
    flags[0].done = 1'b1;
    #1;
    check_eq("t2_req_once", 32'(reqs()), 0);
    check_eq("t3_done_early0", 32'(done), 0);
    cyc();
    #1;                                            // stream 0 pulses again
    check_eq("t3_done_early1", 32'(done), 0);
    check_eq("t3_still_working", 32'(state), 32'(STREAM_WORKING));
    cyc();
    flags[0].done = 1'b0; flags[1].done = 1'b1; flags[2].done = 1'b1;
    #1;
    check_eq("t3_done_early2", 32'(done), 0);
    cyc();
    flags[1].done = 1'b0; flags[2].done = 1'b0;
    #1;
    check_eq("t3_done_pulse", 32'(done), 1);
    cyc();
    #1;
    check_eq("t3_done_single", 32'(done), 0);
    check_eq("t3_job_ready", 32'(job_ready), 1);

    // Test 4: four iterations, base wraps through 2^32
    job_valid = 1'b1; stream_en = 3'b001; nb_iter = 16'd4;
    cfg[0].base_addr = 32'hFFFF_FF00; stride[0] = 32'h100;
    req_count = 0;
    cyc();
    job_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      req_count += 32'(ctrl[0].req_start);
      check_eq("t4_req", 32'(reqs()), 3'b001);
      check_eq("t4_base", ctrl[0].addressgen_ctrl.base_addr, exp_base[i]);
      check_eq("t4_iter", 32'(iter), i);
      cyc();
      flags[0].done = 1'b1;
      #1;
      req_count += 32'(ctrl[0].req_start);
      cyc();
      flags[0].done = 1'b0;
      #1;
      req_count += 32'(ctrl[0].req_start);
      if (i < 3) begin
        check_eq("t4_next_state", 32'(state), 32'(STREAM_WORKING));
        check_eq("t4_next_done", 32'(done), 0);
        cyc();
      end else begin
        check_eq("t4_done_pulse", 32'(done), 1);
        check_eq("t4_iter_last", 32'(iter), 3);
      end
    end
    cyc();
    #1;
    check_eq("t4_req_count", req_count, 4);
    check_eq("t4_job_ready", 32'(job_ready), 1);

    // Test 5: mask 0b101, spurious done on stream 1, then mask 0
    job_valid = 1'b1; stream_en = 3'b101; nb_iter = 16'd1;
    cyc();
    job_valid = 1'b0;
    #1;
    req_seen = reqs();
    check_eq("t5_req", 32'(reqs()), 3'b101);
    cyc();
    flags[0].done = 1'b1; flags[1].done = 1'b1;
    #1;
    req_seen |= reqs();
    check_eq("t5_done_early0", 32'(done), 0);
    cyc();
    flags[0].done = 1'b0;
    #1;
    req_seen |= reqs();
    check_eq("t5_wait_s2", 32'(state), 32'(STREAM_WORKING));
    cyc();
    flags[2].done = 1'b1;
    #1;
    req_seen |= reqs();
    check_eq("t5_done_early1", 32'(done), 0);
    cyc();
    flags[1].done = 1'b0; flags[2].done = 1'b0;
    #1;
    req_seen |= reqs();
    check_eq("t5_done_pulse", 32'(done), 1);
    check_eq("t5_req_seen", 32'(req_seen), 3'b101);
    cyc();
    job_valid = 1'b1; stream_en = 3'b000; nb_iter = 16'd5;
    #1;
    check_eq("t5_mask0_accept", 32'(done), 0);
    cyc();
    job_valid = 1'b0;
    #1;
    check_eq("t5_mask0_done", 32'(done), 1);
    check_eq("t5_mask0_req", 32'(reqs()), 0);
    cyc();
    #1;
    check_eq("t5_mask0_single", 32'(done), 0);
    check_eq("t5_mask0_ready", 32'(job_ready), 1);

    // Test 6: clear during iteration 2 wait, then a fresh job (nb_iter 0)
    job_valid = 1'b1; stream_en = 3'b111; nb_iter = 16'd4;
    cfg[0].base_addr = 32'h100; cfg[1].base_addr = 32'h200; cfg[2].base_addr = 32'h300;
    stride[0] = 32'h10; stride[1] = 32'h10; stride[2] = 32'h10;
    cyc();
    job_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_eq("t6_req", 32'(reqs()), 3'b111);
      cyc();
      for (int k = 0; k < NB; k++) flags[k].done = 1'b1;
      cyc();
      for (int k = 0; k < NB; k++) flags[k].done = 1'b0;
      cyc();
    end
    #1;
    check_eq("t6_req_iter2", 32'(reqs()), 3'b111);
    check_eq("t6_iter2", 32'(iter), 2);
    check_eq("t6_base_iter2", ctrl[0].addressgen_ctrl.base_addr, 32'h120);
    cyc();
    flags[0].done = 1'b1; clear = 1'b1;
    cyc();
    clear = 1'b0; flags[0].done = 1'b0; flags[1].done = 1'b1;
    #1;
    check_eq("t6_clr_state", 32'(state), 32'(STREAM_IDLE));
    check_eq("t6_clr_base", ctrl[0].addressgen_ctrl.base_addr, 0);
    check_eq("t6_clr_req", 32'(reqs()), 0);
    check_eq("t6_clr_iter", 32'(iter), 0);
    check_eq("t6_clr_busy", 32'(busy), 0);
    check_eq("t6_clr_ready", 32'(job_ready), 1);
    cyc();
    flags[1].done = 1'b0;
    #1;
    check_eq("t6_late_done", 32'(done), 0);
    job_valid = 1'b1; stream_en = 3'b010; nb_iter = 16'd0;
    cfg[1].base_addr = 32'hABC0;
    cyc();
    job_valid = 1'b0;
    #1;
    check_eq("t6_new_req", 32'(reqs()), 3'b010);
    check_eq("t6_new_base", ctrl[1].addressgen_ctrl.base_addr, 32'hABC0);
    cyc();
    flags[1].done = 1'b1;
    cyc();
    flags[1].done = 1'b0;
    #1;
    check_eq("t6_new_done", 32'(done), 1);
    check_eq("t6_new_iter", 32'(iter), 0);
    cyc();
    #1;
    check_eq("t6_new_ready", 32'(job_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
